// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRKWAIT
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Parity bit a correct transmitter sends for the given data (zero-extended).
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_vote.sv
// Line synchroniser and 3-sample majority vote around the bit centre.
module uart_rx_vote #(
  parameter int OVS = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_tick,
  input  logic                    i_rx,
  input  logic [$clog2(OVS)-1:0]  i_s_cnt,
  output logic                    o_rx_s,
  output logic                    o_rx_ok,
  output logic                    o_bit,
  output logic                    o_vld
);

  localparam int SW = $clog2(OVS);
  localparam logic [SW-1:0] S_PRE  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVS / 2);
  localparam logic [SW-1:0] S_POST = SW'(OVS / 2 + 1);

  logic [1:0] r_sync;
  logic [1:0] r_ok;
  logic [1:0] r_smp;

  // Two-flop synchroniser; r_ok marks when r_sync carries real line data after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '1;
      r_ok   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      r_ok   <= {r_ok[0], 1'b1};
    end
  end

  assign o_rx_s  = r_sync[1];
  assign o_rx_ok = r_ok[1];

  // Capture the first two samples; the third is taken live at the vote tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_smp <= '0;
    end else if (i_tick) begin
      if (i_s_cnt == S_PRE) r_smp[0] <= o_rx_s;
      if (i_s_cnt == S_MID) r_smp[1] <= o_rx_s;
    end
  end

  assign o_bit = (r_smp[0] & r_smp[1]) | (r_smp[0] & o_rx_s) | (r_smp[1] & o_rx_s);
  assign o_vld = i_tick && (i_s_cnt == S_POST);

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with runtime parity mode and status flags.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_ovs #(
  parameter int WIDTH_DATA = 8,
  parameter int NB_STOP    = 1,
  parameter int OVS        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tick,
  input  logic                  i_rx,
  input  logic [1:0]            i_par,
  input  logic                  i_re,
  output logic [WIDTH_DATA-1:0] o_data,
  output logic                  o_rdy,
  output logic                  o_perr,
  output logic                  o_ferr,
  output logic                  o_ovr,
  output logic                  o_brk
);
  import uart_pkg::*;

  localparam int SW = $clog2(OVS);
  localparam logic [SW-1:0] S_LAST  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_ONE   = SW'(1);
  localparam logic [3:0]    B_DLAST = 4'(WIDTH_DATA - 1);
  localparam logic [3:0]    B_SLAST = 4'(NB_STOP - 1);

  state_t                r_state, w_state_nxt;
  logic [SW-1:0]         r_s_cnt;
  logic [3:0]            r_bit_cnt;
  logic [WIDTH_DATA-1:0] r_shift;
  logic [1:0]            r_par;
  logic                  r_perr, r_ferr, r_armed;
  logic                  w_rx_s, w_rx_ok, w_bit, w_vld;
  logic                  w_bit_end, w_par_en, w_done, w_brk_fin;
`ifdef UART_RX_BREAK_DET_EN
  logic                  r_allz;
  logic                  r_brk;
`endif

  uart_rx_vote #(.OVS(OVS)) u_vote (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_tick  (i_tick),
    .i_rx    (i_rx),
    .i_s_cnt (r_s_cnt),
    .o_rx_s  (w_rx_s),
    .o_rx_ok (w_rx_ok),
    .o_bit   (w_bit),
    .o_vld   (w_vld)
  );

  assign w_bit_end = i_tick && (r_s_cnt == S_LAST);
  assign w_par_en  = (r_par == PAR_EVEN) || (r_par == PAR_ODD);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; the frame ends at the last stop vote, half a bit early.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (i_tick && r_armed && !w_rx_s) w_state_nxt = ST_START;
      ST_START:   if (w_vld && w_bit) w_state_nxt = ST_IDLE;
                  else if (w_bit_end) w_state_nxt = ST_DATA;
      ST_DATA:    if (w_bit_end && r_bit_cnt == B_DLAST)
                    w_state_nxt = w_par_en ? ST_PARITY : ST_STOP;
      ST_PARITY:  if (w_bit_end) w_state_nxt = ST_STOP;
      ST_STOP:    if (w_done) w_state_nxt = w_brk_fin ? ST_BRKWAIT : ST_IDLE;
      ST_BRKWAIT: if (i_tick && w_rx_s) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: frame completion strobe and break qualification.
  always_comb begin
    w_done = (r_state == ST_STOP) && w_vld && (r_bit_cnt == B_SLAST);
`ifdef UART_RX_BREAK_DET_EN
    w_brk_fin = r_allz & ~w_bit;
`else
    w_brk_fin = 1'b0;
`endif
  end

  // Tick counters, per-frame latches and vote consumers.
  // r_armed blocks start detection after reset until the line has been seen idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s_cnt   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_armed   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      r_allz    <= 1'b0;
`endif
    end else begin
      if (w_rx_ok && w_rx_s) r_armed <= 1'b1;
      if (i_tick) begin
        if (w_state_nxt == ST_IDLE || w_state_nxt == ST_BRKWAIT) begin
          r_s_cnt   <= '0;
          r_bit_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
          r_s_cnt   <= S_ONE;
          r_bit_cnt <= '0;
          r_par     <= i_par;
          r_perr    <= 1'b0;
          r_ferr    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          r_allz    <= 1'b1;
`endif
        end else begin
          r_s_cnt <= (r_s_cnt == S_LAST) ? '0 : r_s_cnt + S_ONE;
          if (w_state_nxt != r_state) r_bit_cnt <= '0;
          else if (w_bit_end)         r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end
      if (w_vld) begin
        if (r_state == ST_DATA)   r_shift <= {w_bit, r_shift[WIDTH_DATA-1:1]};
        if (r_state == ST_PARITY) r_perr  <= (w_bit != parity_bit(9'(r_shift), r_par == PAR_ODD));
        if (r_state == ST_STOP && !w_bit) r_ferr <= 1'b1;
`ifdef UART_RX_BREAK_DET_EN
        if (w_bit && (r_state == ST_DATA || r_state == ST_PARITY || r_state == ST_STOP))
          r_allz <= 1'b0;
`endif
      end
    end
  end

  // Host-facing registers; completion takes priority over a coincident read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data <= '0;
      o_rdy  <= 1'b0;
      o_perr <= 1'b0;
      o_ferr <= 1'b0;
      o_ovr  <= 1'b0;
    end else begin
      if (i_re && o_rdy) begin
        o_rdy <= 1'b0;
        o_ovr <= 1'b0;
      end
      if (w_done && !w_brk_fin) begin
        o_data <= r_shift;
        o_perr <= r_perr;
        o_ferr <= r_ferr | ~w_bit;
        o_rdy  <= 1'b1;
        o_ovr  <= o_rdy & ~i_re;
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  // Break flag: set by an all-zero frame, cleared by a read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_brk <= 1'b0;
    end else begin
      if (i_re) r_brk <= 1'b0;
      if (w_done && w_brk_fin) r_brk <= 1'b1;
    end
  end
  assign o_brk = r_brk;
`else
  assign o_brk = 1'b0;
`endif

endmodule
